instr_fetch_queue: RTL

Parametrised instruction-fetch front end for the next-generation MIPS-lite core. It replaces the combinational `pc`/instruction-memory read with a registered fetch PC, a single-outstanding request/response memory handshake, and a FIFO of fetched instructions tagged with their PC. It sits between instruction memory and decode. Decode consumes instructions with a valid/ready handshake and redirects fetch on taken branches and jumps (`beq`, `j`, `jmnor`, `balrnv`, `bltzal`, `jspal`, `baln`).

---
 rtl/instr_fetch_queue.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// Instruction-fetch front end: a registered fetch PC issues single-outstanding
// requests to instruction memory, and returned words are queued together with
// their PC for decode. Decode may redirect fetch at any time (taken branch/jump).
//
// Ports:
//   clk, reset                clock, asynchronous active-high reset
//   mem_req/mem_addr/mem_gnt  request channel (byte address, held until grant)
//   mem_rvalid/mem_rdata      response channel (one response per grant)
//   inst_valid/inst_ready     queue head handshake towards decode
//   inst_data/inst_pc         head instruction and its PC
//   inst_pcplus4              head PC + 4 (link value)
//   redirect_valid/_pc        flush queue and restart fetch at redirect_pc
module instr_fetch_queue #(
  parameter int                XLEN        = 32,
  parameter int                IMEM_ADDR_W = 5,
  parameter int                QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0]   RESET_PC    = {XLEN{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_req,
  output logic [IMEM_ADDR_W-1:0] mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [XLEN-1:0]        inst_data,
  output logic [XLEN-1:0]        inst_pc,
  output logic [XLEN-1:0]        inst_pcplus4,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc
);

  localparam int              PW          = $clog2(QUEUE_DEPTH);
  localparam int              CW          = PW + 1;
  localparam logic [XLEN-1:0] PC_STEP     = XLEN'(4);
  localparam logic [XLEN-1:0] PC_LOW_MASK = XLEN'(3);
  localparam logic [PW-1:0]   PTR_ONE     = PW'(1);
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [CW:0]     DEPTH_OCC   = (CW+1)'(QUEUE_DEPTH);

  // Fetch / handshake state
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_hold_pc;     // PC of a request that is waiting for grant
  logic [XLEN-1:0] r_out_pc;      // PC of the request in flight
  logic            r_hold;
  logic            r_outstanding;
  logic            r_stale;       // in-flight (or held) request belongs to a flushed path

  // Queue state
  logic [XLEN-1:0] r_q_pc   [QUEUE_DEPTH];
  logic [XLEN-1:0] r_q_inst [QUEUE_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic [XLEN-1:0] w_req_pc;
  logic [XLEN-1:0] w_redir_target;
  logic [CW:0]     w_occ;
  logic            w_rsp_busy;
  logic            w_new_req;
  logic            w_grant;
  logic            w_grant_stale;
  logic            w_push;
  logic            w_pop;

  // A response in this cycle frees the single outstanding slot right away,
  // which is what allows back-to-back fetch at one instruction per cycle.
  assign w_rsp_busy = (r_outstanding | r_stale) & ~mem_rvalid;

  // Occupancy counts queued entries plus a live (non-stale) request in flight;
  // a response arriving now is still counted, since it turns into a push.
  assign w_occ = {1'b0, r_count} + {{CW{1'b0}}, (r_outstanding & ~r_stale)};

  // Fresh requests are suppressed in a redirect cycle so the first request
  // after a redirect is always for the target.
  assign w_new_req = ~reset & ~redirect_valid & ~w_rsp_busy & (w_occ < DEPTH_OCC);

  // A held request keeps mem_req and mem_addr stable until it is granted.
  assign mem_req        = r_hold | w_new_req;
  assign w_req_pc       = r_hold ? r_hold_pc : r_fetch_pc;
  assign mem_addr       = w_req_pc[IMEM_ADDR_W-1:0];
  assign w_grant        = mem_req & mem_gnt;
  assign w_grant_stale  = r_hold & r_stale;
  assign w_redir_target = redirect_pc & ~PC_LOW_MASK;

  assign w_push = mem_rvalid & r_outstanding & ~r_stale & ~redirect_valid;
  assign w_pop  = inst_valid & inst_ready & ~redirect_valid;

  assign inst_valid   = (r_count != {CW{1'b0}});
  assign inst_data    = inst_valid ? r_q_inst[r_head] : {XLEN{1'b0}};
  assign inst_pc      = inst_valid ? r_q_pc[r_head]   : {XLEN{1'b0}};
  assign inst_pcplus4 = inst_pc + PC_STEP;

  // Fetch PC, request hold and outstanding/stale tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_hold_pc     <= RESET_PC;
      r_out_pc      <= {XLEN{1'b0}};
      r_hold        <= 1'b0;
      r_outstanding <= 1'b0;
      r_stale       <= 1'b0;
    end else begin
      r_hold    <= mem_req & ~mem_gnt;
      r_hold_pc <= w_req_pc;

      if (redirect_valid) begin
        r_fetch_pc <= w_redir_target;
      end else if (w_grant && !w_grant_stale) begin
        r_fetch_pc <= r_fetch_pc + PC_STEP;
      end

      if (w_grant) begin
        r_outstanding <= 1'b1;
        r_out_pc      <= w_req_pc;
      end else if (mem_rvalid) begin
        r_outstanding <= 1'b0;
      end

      // Hold and outstanding are mutually exclusive, so a redirect marks
      // whichever one exists; a same-cycle response is dropped via w_push.
      if (redirect_valid && ((r_outstanding && !mem_rvalid) || r_hold)) begin
        r_stale <= 1'b1;
      end else if (mem_rvalid) begin
        r_stale <= 1'b0;
      end
    end
  end

  // Queue pointers and count; redirect empties the queue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (redirect_valid) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents are only observed through a valid head
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_tail]   <= r_out_pc;
      r_q_inst[r_tail] <= mem_rdata;
    end
  end

endmodule
